fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Owns the program counter and consumes the redirect interface from the branch unit (pc_sel, pc_branch).
- Sequential PC update: +4, hold on stall, or redirect.
- Captures redirects that arrive while the front end is stalled.
- Generates pipeline flush pulses and a fetch-valid qualifier that covers instruction-memory latency after a redirect.
- Sits in IF, between the hazard unit and the instruction memory address port.

Parameters:
PW, 9, PC width in bits; matches branch unit PC width; PC wraps modulo 2^PW.
RESET_PC, 0, PW-bit PC value loaded on reset.
FLUSH_LAT, 1, cycles fetch_valid stays low after an accepted redirect (1..7).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit front-end hold; PC must not advance
pc_sel  input  1  redirect request from branch unit (jal/jalr/taken branch)
pc_branch  input  32  redirect target from branch unit
pc  output  PW  current fetch address to instruction memory
flush_if_id  output  1  clear IF/ID register at next edge
flush_id_ex  output  1  clear ID/EX register at next edge
fetch_valid  output  1  instruction returned for pc is valid
misalign_err  output  1  sticky: an accepted target had bits [1:0] != 0

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset has priority over every other input in the same cycle.
- Reset values:
  - pc=RESET_PC, state=RUN, pending target=0, bubble counter=0.
  - flush_if_id=0, flush_id_ex=0, misalign_err=0.
  - fetch_valid=0 in the reset cycle; 1 from the first cycle after reset is released.
- States: RUN, PENDING, BUBBLE.
- Target conversion:
  - tgt = {pc_branch[PW-1:2], 2'b00}.
  - Bits above PW-1 are discarded silently.
  - If pc_branch[1:0] != 0 on an accepted redirect, misalign_err sets; it clears only on reset.
- Accept event:
  - RUN: pc_sel && !stall.
  - PENDING: !stall, using the latched target.
- Cycle of accept (t):
  - flush_if_id=1 and flush_id_ex=1, combinationally in cycle t only.
  - pc(t+1)=tgt.
  - Bubble counter loads FLUSH_LAT; state goes to BUBBLE.
- RUN, no redirect:
  - !stall: pc <= pc+4 (wraps at 2^PW).
  - stall: pc held.
  - Both flush outputs 0.
- RUN, pc_sel && stall:
  - Latch tgt (and its misalign bit) into the pending register; go to PENDING.
  - pc held; no flush asserted.
- PENDING:
  - pc held while stall=1.
  - Further pc_sel pulses are ignored. The first (oldest) redirect wins because it squashes younger instructions.
  - When stall=0, perform the accept event using the latched target.
- BUBBLE:
  - fetch_valid=0; counter decrements each cycle.
  - pc advances +4 per cycle unless stall.
  - At counter==1 with !stall, go to RUN; fetch_valid=1 the next cycle.
  - While stall=1 the counter holds.
- fetch_valid:
  - Low in the FLUSH_LAT cycles following an accept.
  - High otherwise, excluding the reset cycle.
- pc_sel in BUBBLE (a new redirect, e.g. jalr resolving):
  - Treated as accept if !stall: re-flush, reload target and counter.
  - Treated as PENDING capture if stall.
- Reset in PENDING or BUBBLE discards the pending target and the counter.
- Latency: redirect-to-new-pc is 1 cycle; redirect-to-fetch_valid is FLUSH_LAT+1 cycles.

Decomposition:
- Shared package (core_pkg): fetch state enum {RUN, PENDING, BUBBLE}, INSTR_BYTES=4 constant, PC width default.
- One natural sub-module: redirect_hold_reg. It holds the PENDING target/valid/misalign bit, with capture and clear controls.

Test Plan:
1. Reset release, stall=0, no pc_sel for 4 cycles -> pc = 0,4,8,12; fetch_valid=1 from the cycle after reset; flushes 0.
2. pc=0x1F8, free-run 3 cycles -> pc = 0x1FC, 0x000, 0x004 (wrap at PW=9).
3. At pc=0x010, pc_sel=1, pc_branch=0x0000_0080, stall=0 -> both flushes high that cycle only; next pc=0x080; fetch_valid low 1 cycle (FLUSH_LAT=1), then high; pc then 0x084.
4. stall=1, pc_sel=1, target 0x040, then pc_sel=1, target 0x100 while still stalled, stall drops after 3 cycles -> pc held throughout; no flush until stall drops; accept uses 0x040; pc=0x040 next cycle.
5. pc_sel=1, pc_branch=0x0000_0206 -> pc=0x004 (bit 9 dropped, [1:0] cleared); misalign_err=1 and stays 1 until reset.
6. Reset asserted during PENDING with target 0x0C0 -> pc=RESET_PC next cycle; stall drop afterwards causes no redirect and no flush.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch-side types and constants.
// Fetch state enum, instruction size, default PC width.
package core_pkg;

  localparam int PC_W        = 9;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    RUN,
    PENDING,
    BUBBLE
  } fetch_state_e;

endpackage

// File: rtl/redirect_hold_reg.sv
// Holds a redirect that arrived while the front end was stalled.
// Ports: capture/clear controls, target+misalign in, valid/target/misalign out.
module redirect_hold_reg
  import core_pkg::*;
#(
  parameter int PW = PC_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          capture,
  input  logic          clear,
  input  logic [PW-1:0] tgt_in,
  input  logic          mis_in,
  output logic          valid,
  output logic [PW-1:0] tgt,
  output logic          mis
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      tgt   <= '0;
      mis   <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      tgt   <= tgt_in;
      mis   <= mis_in;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter owner: +4 / hold / redirect, stalled-redirect capture,
// flush pulses, fetch_valid qualifier. Ports: clk, reset, stall, pc_sel,
// pc_branch in; pc, flush_if_id, flush_id_ex, fetch_valid, misalign_err out.
module fetch_pc_unit
  import core_pkg::*;
#(
  parameter int              PW        = PC_W,
  parameter logic [PW-1:0]   RESET_PC  = '0,
  parameter int              FLUSH_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          pc_sel,
  input  logic [31:0]   pc_branch,
  output logic [PW-1:0] pc,
  output logic          flush_if_id,
  output logic          flush_id_ex,
  output logic          fetch_valid,
  output logic          misalign_err
);

  fetch_state_e  state_q;
  logic [PW-1:0] pc_q;
  logic [2:0]    cnt_q;
  logic          mis_q;

  logic [PW-1:0] tgt_new;
  logic          mis_new;
  logic          hold_valid;
  logic [PW-1:0] hold_tgt;
  logic          hold_mis;
  logic          in_pend;
  logic          accept;
  logic          capture;
  logic [PW-1:0] acc_tgt;
  logic          acc_mis;
  logic          unused_hi;

  // Upper target bits beyond the PC width are dropped on purpose.
  assign unused_hi = ^pc_branch[31:PW];

  assign tgt_new = {pc_branch[PW-1:2], 2'b00};
  assign mis_new = |pc_branch[1:0];

  assign in_pend = hold_valid;

  // Oldest redirect wins: a held target beats a new pc_sel.
  assign accept  = !reset && !stall
                && (in_pend || pc_sel);
  assign capture = !reset && stall
                && pc_sel && !in_pend;

  assign acc_tgt = in_pend ? hold_tgt : tgt_new;
  assign acc_mis = in_pend ? hold_mis : mis_new;

  redirect_hold_reg #(
    .PW(PW)
  ) u_hold (
    .clk    (clk),
    .reset  (reset),
    .capture(capture),
    .clear  (accept && in_pend),
    .tgt_in (tgt_new),
    .mis_in (mis_new),
    .valid  (hold_valid),
    .tgt    (hold_tgt),
    .mis    (hold_mis)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else if (accept) begin
      pc_q    <= acc_tgt;
      state_q <= BUBBLE;
      cnt_q   <= 3'(FLUSH_LAT);
      if (acc_mis) mis_q <= 1'b1;
    end else if (capture) begin
      state_q <= PENDING;
      cnt_q   <= '0;
    end else if (!stall) begin
      pc_q <= pc_q + PW'(INSTR_BYTES);
      if (state_q == BUBBLE) begin
        cnt_q <= cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_q <= RUN;
      end
    end
  end

  assign pc           = pc_q;
  assign flush_if_id  = accept;
  assign flush_id_ex  = accept;
  assign fetch_valid  = !reset
                     && (state_q != BUBBLE);
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit.
// Directed scenarios plus random traffic against a behavioural model.
module tb_fetch_pc_unit;

  localparam int PW        = 9;
  localparam int FLUSH_LAT = 1;
  localparam logic [PW-1:0] RST_PC = '0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          pc_sel = 1'b0;
  logic [31:0]   pc_branch = '0;
  logic [PW-1:0] pc;
  logic          flush_if_id;
  logic          flush_id_ex;
  logic          fetch_valid;
  logic          misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_unit #(
    .PW(PW),
    .RESET_PC(RST_PC),
    .FLUSH_LAT(FLUSH_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .pc_sel      (pc_sel),
    .pc_branch   (pc_branch),
    .pc          (pc),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .fetch_valid (fetch_valid),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: PC value, an optional held redirect, the number
  // of blind fetch cycles still owed, and the sticky misalign flag.
  logic [PW-1:0] m_pc = '0;
  bit            m_held = 0;
  logic [PW-1:0] m_held_tgt = '0;
  bit            m_held_mis = 0;
  int            m_blind = 0;
  bit            m_mis = 0;
  bit            m_live = 0;

  function automatic logic [PW-1:0] to_tgt(input logic [31:0] b);
    int unsigned v;
    v = b % (1 << PW);
    v = v - (v % 4);
    return PW'(v);
  endfunction

  function automatic bit redirect_now();
    return !reset && !stall && (m_held || pc_sel);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc = RST_PC;
      m_held = 0;
      m_blind = 0;
      m_mis = 0;
      m_live = 1;
    end else if (redirect_now()) begin
      if (m_held) begin
        m_pc = m_held_tgt;
        m_mis = m_mis | m_held_mis;
      end else begin
        m_pc = to_tgt(pc_branch);
        m_mis = m_mis | (pc_branch % 4 != 0);
      end
      m_held = 0;
      m_blind = FLUSH_LAT;
    end else if (stall && pc_sel && !m_held) begin
      m_held = 1;
      m_held_tgt = to_tgt(pc_branch);
      m_held_mis = (pc_branch % 4 != 0);
      m_blind = 0;
    end else if (!stall) begin
      m_pc = PW'((int'(m_pc) + 4) % (1 << PW));
      if (m_blind > 0) m_blind = m_blind - 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model compare on every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_flush_if_id", 32'(flush_if_id), 32'(redirect_now()));
      chk("m_flush_id_ex", 32'(flush_id_ex), 32'(redirect_now()));
      chk("m_fetch_valid", 32'(fetch_valid),
          32'(!reset && m_blind == 0));
      chk("m_misalign", 32'(misalign_err), 32'(m_mis));
      if (!reset) chk("m_pc", 32'(pc), 32'(m_pc));
    end
  end

  task automatic drive(input logic r, input logic s, input logic p,
                       input logic [31:0] b);
    @(posedge clk);
    #1;
    reset = r;
    stall = s;
    pc_sel = p;
    pc_branch = b;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // 1: reset then free-run
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'd0);
    chk("rst_flush", 32'(flush_if_id), 32'd0);
    idle();
    chk("t1_pc0", 32'(pc), 32'h000);
    chk("t1_fv", 32'(fetch_valid), 32'd1);
    chk("t1_mis", 32'(misalign_err), 32'd0);
    idle();
    chk("t1_pc4", 32'(pc), 32'h004);
    idle();
    chk("t1_pc8", 32'(pc), 32'h008);
    idle();
    chk("t1_pc12", 32'(pc), 32'h00C);
    chk("t1_flush", 32'(flush_id_ex), 32'd0);

    // 2: wrap at 2^PW
    drive(1'b0, 1'b0, 1'b1, 32'h0000_01F8);
    chk("t2_flush", 32'(flush_if_id), 32'd1);
    idle();
    chk("t2_pc", 32'(pc), 32'h1F8);
    chk("t2_fv_low", 32'(fetch_valid), 32'd0);
    idle();
    chk("t2_pc1", 32'(pc), 32'h1FC);
    chk("t2_fv_high", 32'(fetch_valid), 32'd1);
    idle();
    chk("t2_wrap", 32'(pc), 32'h000);
    idle();
    chk("t2_pc3", 32'(pc), 32'h004);

    // 3: redirect, then second redirect during the bubble
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0010);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0080);
    chk("t3_pc10", 32'(pc), 32'h010);
    chk("t3_reflush", 32'(flush_id_ex), 32'd1);
    idle();
    chk("t3_pc80", 32'(pc), 32'h080);
    chk("t3_fv_low", 32'(fetch_valid), 32'd0);
    chk("t3_noflush", 32'(flush_if_id), 32'd0);
    idle();
    chk("t3_pc84", 32'(pc), 32'h084);
    chk("t3_fv_high", 32'(fetch_valid), 32'd1);

    // 4: redirect held across a stall, oldest wins
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    chk("t4_hold0", 32'(pc), 32'h088);
    chk("t4_noflush0", 32'(flush_if_id), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    chk("t4_hold1", 32'(pc), 32'h088);
    chk("t4_noflush1", 32'(flush_if_id), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t4_hold2", 32'(pc), 32'h088);
    idle();
    chk("t4_accept", 32'(flush_if_id), 32'd1);
    idle();
    chk("t4_pc40", 32'(pc), 32'h040);

    // 5: truncated, misaligned target
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0206);
    chk("t5_mis_pre", 32'(misalign_err), 32'd0);
    idle();
    chk("t5_pc", 32'(pc), 32'h004);
    chk("t5_mis", 32'(misalign_err), 32'd1);
    idle();
    idle();
    chk("t5_sticky", 32'(misalign_err), 32'd1);

    // 6: reset discards a pending redirect
    drive(1'b0, 1'b1, 1'b1, 32'h0000_00C0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_rst_flush", 32'(flush_if_id), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t6_pc_rst", 32'(pc), 32'(RST_PC));
    chk("t6_mis_clr", 32'(misalign_err), 32'd0);
    idle();
    chk("t6_noflush", 32'(flush_if_id), 32'd0);
    chk("t6_pc", 32'(pc), 32'(RST_PC));
    idle();
    chk("t6_pc4", 32'(pc), 32'h004);

    // random traffic, checked by the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] b;
      b = $urandom;
      if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) == 0,
            b);
    end

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
